// File: rtl/sid_reg_arbiter.sv
// sid_reg_arbiter: shares the SID register write port between two requesters.
// Each requester pushes {voice, addr, data} words through valid/ready into
// its own FIFO. A round-robin arbiter pops one word at a time and replays it
// onto the SID register bus with setup / strobe / hold timing.
//
// Optional build macro: SID_ARB_FILT_PRIO_EN
//   When defined, a FIFO whose head targets voice 3 (filter bank) wins over
//   one whose head does not, regardless of the round-robin pointer.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid / reqN_ready   push handshake for requester N (ready = !full)
//   reqN_voice/addr/data      word fields for requester N
//   bus_voice/addr/data       SID register bus fields (change only on a pop)
//   bus_we                    SID write strobe
//   busy                      arbiter FSM not in IDLE
//   grant_id                  source requester of the word on the bus
//   lvl0, lvl1                FIFO occupancy, 0..FIFO_DEPTH
module sid_reg_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 1,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req0_valid,
  output logic                          req0_ready,
  input  logic [1:0]                    req0_voice,
  input  logic [2:0]                    req0_addr,
  input  logic [7:0]                    req0_data,
  input  logic                          req1_valid,
  output logic                          req1_ready,
  input  logic [1:0]                    req1_voice,
  input  logic [2:0]                    req1_addr,
  input  logic [7:0]                    req1_data,
  output logic [1:0]                    bus_voice,
  output logic [2:0]                    bus_addr,
  output logic [7:0]                    bus_data,
  output logic                          bus_we,
  output logic                          busy,
  output logic                          grant_id,
  output logic [$clog2(FIFO_DEPTH):0]   lvl0,
  output logic [$clog2(FIFO_DEPTH):0]   lvl1
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned LW      = AW + 1;
  localparam int unsigned MAX_SS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int unsigned MAX_CYC = (MAX_SS > HOLD_CYC) ? MAX_SS : HOLD_CYC;
  localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  typedef struct packed {
    logic [1:0] voice;
    logic [2:0] addr;
    logic [7:0] data;
  } sid_word_t;

  // FIFO storage and bookkeeping, index 0/1 = requester
  sid_word_t       mem [2][FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr [2];
  logic [AW-1:0]   rd_ptr [2];
  logic [LW-1:0]   lvl [2];
  logic [LW-1:0]   lvl_nxt [2];
  logic [1:0]      ready_q;
  logic [1:0]      push;
  logic [1:0]      pop;
  sid_word_t       push_word [2];
  sid_word_t       head [2];
  logic            ne0;
  logic            ne1;

  // Arbiter / bus registers
  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  sid_word_t       bus_word;
  sid_word_t       word_nxt;
  logic            grant_nxt;
  logic            last_grant;
  logic            last_nxt;
  logic            we_nxt;
  logic            sel;

  // Input word packing, push qualification and FIFO heads
  always_comb begin
    push_word[0] = {req0_voice, req0_addr, req0_data};
    push_word[1] = {req1_voice, req1_addr, req1_data};
    push         = {req1_valid & ready_q[1], req0_valid & ready_q[0]};
    for (int i = 0; i < 2; i++) begin
      head[i]    = mem[i][rd_ptr[i]];
      lvl_nxt[i] = lvl[i] + LW'(push[i]) - LW'(pop[i]);
    end
  end

  assign ne0 = (lvl[0] != '0);
  assign ne1 = (lvl[1] != '0);

  // FIFO data array; contents need no reset since pointers are cleared
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst && push[i]) begin
        mem[i][wr_ptr[i]] <= push_word[i];
      end
    end
  end

  // FIFO pointers, levels and registered ready (= next level not full)
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        lvl[i]    <= '0;
      end
      ready_q <= 2'b11;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        lvl[i]     <= lvl_nxt[i];
        ready_q[i] <= (lvl_nxt[i] != LW'(FIFO_DEPTH));
      end
    end
  end

  // Winner selection: round robin on a tie, optional filter-bank priority
  always_comb begin
    if (ne0 && ne1) sel = ~last_grant;
    else            sel = ne1;
`ifdef SID_ARB_FILT_PRIO_EN
    if (ne0 && ne1 && ((head[0].voice == 2'd3) != (head[1].voice == 2'd3))) begin
      sel = (head[1].voice == 2'd3);
    end
`endif
  end

  // State register plus registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bus_word   <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      bus_we     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bus_word   <= word_nxt;
      grant_id   <= grant_nxt;
      last_grant <= last_nxt;
      bus_we     <= we_nxt;
      busy       <= (state_nxt != ST_IDLE);
    end
  end

  // Next-state logic; cnt is reloaded with (cycles - 1) on every state entry
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 2'b00;
    word_nxt  = bus_word;
    grant_nxt = grant_id;
    last_nxt  = last_grant;
    we_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ne0 || ne1) begin
          pop       = sel ? 2'b10 : 2'b01;
          word_nxt  = sel ? head[1] : head[0];
          grant_nxt = sel;
          last_nxt  = sel;
          state_nxt = ST_SETUP;
          cnt_nxt   = CW'(SETUP_CYC - 1);
        end
      end
      ST_SETUP: begin
        if (cnt == '0) begin
          state_nxt = ST_STROBE;
          cnt_nxt   = CW'(STROBE_CYC - 1);
          we_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_STROBE: begin
        if (cnt == '0) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = CW'(HOLD_CYC - 1);
        end else begin
          cnt_nxt = cnt - CW'(1);
          we_nxt  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) state_nxt = ST_IDLE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus_voice  = bus_word.voice;
  assign bus_addr   = bus_word.addr;
  assign bus_data   = bus_word.data;
  assign req0_ready = ready_q[0];
  assign req1_ready = ready_q[1];
  assign lvl0       = lvl[0];
  assign lvl1       = lvl[1];

endmodule

// File: tb/tb_sid_reg_arbiter.sv
// Directed bench for sid_reg_arbiter: default-parameter instance plus a
// STROBE_CYC=3 / HOLD_CYC=2 instance for the stretched-timing case.
module tb_sid_reg_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [1:0] req0_voice = '0, req1_voice = '0;
  logic [2:0] req0_addr = '0, req1_addr = '0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready;
  logic [1:0] bus_voice;
  logic [2:0] bus_addr;
  logic [7:0] bus_data;
  logic       bus_we, busy, grant_id;
  logic [2:0] lvl0, lvl1;

  logic       b_valid = 1'b0, b_zero = 1'b0;
  logic [1:0] b_voice = '0, b_zv = '0;
  logic [2:0] b_addr = '0, b_za = '0;
  logic [7:0] b_data = '0, b_zd = '0;
  logic       b_ready, b_r1_ready;
  logic [1:0] b_bus_voice;
  logic [2:0] b_bus_addr;
  logic [7:0] b_bus_data;
  logic       b_bus_we, b_busy, b_grant;
  logic [2:0] b_lvl0, b_lvl1;

  sid_reg_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_voice(req0_voice),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_voice(req1_voice),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .bus_voice(bus_voice), .bus_addr(bus_addr), .bus_data(bus_data),
    .bus_we(bus_we), .busy(busy), .grant_id(grant_id), .lvl0(lvl0), .lvl1(lvl1)
  );

  sid_reg_arbiter #(.FIFO_DEPTH(4), .SETUP_CYC(1), .STROBE_CYC(3), .HOLD_CYC(2)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(b_valid), .req0_ready(b_ready), .req0_voice(b_voice),
    .req0_addr(b_addr), .req0_data(b_data),
    .req1_valid(b_zero), .req1_ready(b_r1_ready), .req1_voice(b_zv),
    .req1_addr(b_za), .req1_data(b_zd),
    .bus_voice(b_bus_voice), .bus_addr(b_bus_addr), .bus_data(b_bus_data),
    .bus_we(b_bus_we), .busy(b_busy), .grant_id(b_grant), .lvl0(b_lvl0), .lvl1(b_lvl1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       g;
    logic [1:0] v;
    logic [2:0] a;
    logic [7:0] d;
  } rec_t;

  // Strobe monitors: record the word at each rising bus_we (main DUT) and
  // rise time / pulse width (stretched DUT)
  rec_t sq[$];
  int   sc[$];
  logic prev_we = 1'b0;
  int   b_rise[$];
  int   b_len[$];
  int   b_run = 0;
  logic b_prev = 1'b0;

  always @(negedge clk) begin
    if (bus_we && !prev_we) begin
      sq.push_back({grant_id, bus_voice, bus_addr, bus_data});
      sc.push_back(cyc);
    end
    prev_we = bus_we;
    if (b_bus_we) b_run++;
    if (b_bus_we && !b_prev) b_rise.push_back(cyc);
    if (!b_bus_we && b_prev) begin
      b_len.push_back(b_run);
      b_run = 0;
    end
    b_prev = b_bus_we;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sq.delete(); sc.delete(); b_rise.delete(); b_len.delete(); b_run = 0;
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int t = 0;
    while (sq.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (sq.size() < n) begin
      bad++;
      $display("FAIL strobe_wait: got %0d strobes, required %0d", sq.size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    do_reset();
    total += 12;
    if (bus_we !== 1'b0)     begin bad++; $display("FAIL rst_we: %b vs 0", bus_we); end
    if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: %b vs 0", busy); end
    if (grant_id !== 1'b0)   begin bad++; $display("FAIL rst_grant: %b vs 0", grant_id); end
    if (bus_voice !== 2'd0)  begin bad++; $display("FAIL rst_voice: %0d vs 0", bus_voice); end
    if (bus_addr !== 3'd0)   begin bad++; $display("FAIL rst_addr: %0d vs 0", bus_addr); end
    if (bus_data !== 8'h00)  begin bad++; $display("FAIL rst_data: %h vs 00", bus_data); end
    if (lvl0 !== 3'd0)       begin bad++; $display("FAIL rst_lvl0: %0d vs 0", lvl0); end
    if (lvl1 !== 3'd0)       begin bad++; $display("FAIL rst_lvl1: %0d vs 0", lvl1); end
    if (req0_ready !== 1'b1) begin bad++; $display("FAIL rst_rdy0: %b vs 1", req0_ready); end
    if (req1_ready !== 1'b1) begin bad++; $display("FAIL rst_rdy1: %b vs 1", req1_ready); end
    if ({b_r1_ready, b_lvl1} !== 4'b1000) begin
      bad++; $display("FAIL rst_b_r1: %b vs 1000", {b_r1_ready, b_lvl1});
    end
    if ({b_bus_voice, b_bus_addr} !== 5'd0) begin
      bad++; $display("FAIL rst_b_bus: %h vs 0", {b_bus_voice, b_bus_addr});
    end
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1'b1; req0_voice = 2'd0; req0_addr = 3'd1; req0_data = 8'h1C;
    @(negedge clk);  // after E0
    req0_valid = 1'b0;
    total += 2;
    if (lvl0 !== 3'd1) begin bad++; $display("FAIL single_lvl: %0d vs 1", lvl0); end
    if (busy !== 1'b0) begin bad++; $display("FAIL single_busy0: %b vs 0", busy); end
    @(negedge clk);  // after E1
    total += 3;
    if ({bus_voice, bus_addr, bus_data} !== {2'd0, 3'd1, 8'h1C}) begin
      bad++; $display("FAIL single_bus: %h vs %h", {bus_voice, bus_addr, bus_data}, {2'd0, 3'd1, 8'h1C});
    end
    if ({grant_id, busy, bus_we} !== 3'b010) begin
      bad++; $display("FAIL single_e1: g/busy/we %b vs 010", {grant_id, busy, bus_we});
    end
    if (lvl0 !== 3'd0) begin bad++; $display("FAIL single_pop: %0d vs 0", lvl0); end
    @(negedge clk);  // after E2
    total++;
    if (bus_we !== 1'b1) begin bad++; $display("FAIL single_we_e2: %b vs 1", bus_we); end
    @(negedge clk);  // after E3
    total++;
    if ({busy, bus_we} !== 2'b10) begin bad++; $display("FAIL single_e3: %b vs 10", {busy, bus_we}); end
    @(negedge clk);  // after E4
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_e4_busy: %b vs 0", busy); end
  endtask

  task automatic test_contention();
    rec_t exp;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req0_valid = 1'b1; req0_voice = 2'd0; req0_addr = 3'(k); req0_data = 8'h10 + 8'(k);
      req1_valid = 1'b1; req1_voice = 2'd1; req1_addr = 3'(k); req1_data = 8'h20 + 8'(k);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_strobes(8, 100);
    repeat (10) @(negedge clk);
    total++;
    if (sq.size() != 8) begin bad++; $display("FAIL cont_count: %0d vs 8", sq.size()); end
    for (int k = 0; k < 8 && k < int'(sq.size()); k++) begin
      exp.g = 1'(k % 2);
      exp.v = exp.g ? 2'd1 : 2'd0;
      exp.a = 3'(k / 2);
      exp.d = (exp.g ? 8'h20 : 8'h10) + 8'(k / 2);
      total++;
      if (sq[k] !== exp) begin bad++; $display("FAIL cont_word%0d: %h vs %h", k, sq[k], exp); end
      if (k > 0) begin
        total++;
        if (sc[k] - sc[k-1] != 4) begin
          bad++; $display("FAIL cont_gap%0d: %0d vs 4", k, sc[k] - sc[k-1]);
        end
      end
    end
    total++;
    if ({lvl0, lvl1} !== 6'd0) begin bad++; $display("FAIL cont_lvl: %h vs 0", {lvl0, lvl1}); end
  endtask

  task automatic test_backpressure();
    int   t;
    logic saw_full = 1'b0;
    rec_t exp;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      req0_valid = 1'b1; req0_voice = 2'd2; req0_addr = 3'(k); req0_data = 8'h40 + 8'(k);
      t = 0;
      forever begin
        total++;
        if (req0_ready !== (lvl0 != 3'd4)) begin
          bad++; $display("FAIL bp_ready: ready %b with lvl0 %0d", req0_ready, lvl0);
        end
        if (req0_ready === 1'b1 || t >= 50) break;
        saw_full = 1'b1;
        @(negedge clk);
        t++;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    total++;
    if (saw_full !== 1'b1) begin bad++; $display("FAIL bp_full_seen: %b vs 1", saw_full); end
    wait_strobes(6, 100);
    repeat (6) @(negedge clk);
    for (int k = 0; k < 6 && k < int'(sq.size()); k++) begin
      exp = {1'b0, 2'd2, 3'(k), 8'h40 + 8'(k)};
      total++;
      if (sq[k] !== exp) begin bad++; $display("FAIL bp_word%0d: %h vs %h", k, sq[k], exp); end
    end
    total += 2;
    if (sq.size() != 6) begin bad++; $display("FAIL bp_count: %0d vs 6", sq.size()); end
    if (lvl0 !== 3'd0)  begin bad++; $display("FAIL bp_lvl_end: %0d vs 0", lvl0); end
  endtask

  task automatic test_reset_mid_strobe();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      req0_valid = 1'b1; req0_voice = 2'd0; req0_addr = 3'(k); req0_data = 8'h50 + 8'(k);
      req1_valid = 1'b1; req1_voice = 2'd1; req1_addr = 3'(k); req1_data = 8'h60 + 8'(k);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);  // after E2: strobing, 3 words queued
    total++;
    if ({bus_we, lvl0, lvl1} !== {1'b1, 3'd1, 3'd2}) begin
      bad++; $display("FAIL mid_pre: we/lvl0/lvl1 %b vs 1001010", {bus_we, lvl0, lvl1});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total += 3;
    if ({bus_we, busy} !== 2'b00) begin bad++; $display("FAIL mid_we: %b vs 00", {bus_we, busy}); end
    if ({lvl0, lvl1} !== 6'd0) begin bad++; $display("FAIL mid_lvl: %h vs 0", {lvl0, lvl1}); end
    if ({req0_ready, req1_ready} !== 2'b11) begin
      bad++; $display("FAIL mid_rdy: %b vs 11", {req0_ready, req1_ready});
    end
    sq.delete(); sc.delete();
    repeat (20) @(negedge clk);
    total++;
    if (sq.size() != 0) begin bad++; $display("FAIL mid_quiet: %0d strobes vs 0", sq.size()); end
  endtask

  task automatic test_stretched();
    int t = 0;
    do_reset();
    b_valid = 1'b1; b_voice = 2'd1; b_addr = 3'd4; b_data = 8'h33;
    @(negedge clk);
    b_addr = 3'd5; b_data = 8'h34;
    @(negedge clk);
    b_valid = 1'b0;
    while (b_len.size() < 2 && t < 60) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (b_len.size() < 2) begin
      bad++; $display("FAIL str_wait: %0d pulses vs 2", b_len.size());
    end else begin
      total += 3;
      if (b_len[0] != 3) begin bad++; $display("FAIL str_len0: %0d vs 3", b_len[0]); end
      if (b_len[1] != 3) begin bad++; $display("FAIL str_len1: %0d vs 3", b_len[1]); end
      if (b_rise[1] - b_rise[0] != 7) begin
        bad++; $display("FAIL str_gap: %0d vs 7", b_rise[1] - b_rise[0]);
      end
    end
    repeat (3) @(negedge clk);
    total++;
    if ({b_bus_data, b_grant, b_busy, b_lvl0} !== {8'h34, 1'b0, 1'b0, 3'd0}) begin
      bad++; $display("FAIL str_end: %h vs %h", {b_bus_data, b_grant, b_busy, b_lvl0},
                      {8'h34, 1'b0, 1'b0, 3'd0});
    end
  endtask

  task automatic test_filter_prio();
    logic exp_g;
`ifdef SID_ARB_FILT_PRIO_EN
    exp_g = 1'b1;
`else
    exp_g = 1'b0;
`endif
    do_reset();
    req0_valid = 1'b1; req0_voice = 2'd0; req0_addr = 3'd2; req0_data = 8'h05;
    req1_valid = 1'b1; req1_voice = 2'd3; req1_addr = 3'd3; req1_data = 8'h1F;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);  // after first grant
    total += 2;
    if (grant_id !== exp_g) begin bad++; $display("FAIL prio_first: %b vs %b", grant_id, exp_g); end
    if (bus_data !== (exp_g ? 8'h1F : 8'h05)) begin
      bad++; $display("FAIL prio_data: %h vs %h", bus_data, exp_g ? 8'h1F : 8'h05);
    end
    repeat (4) @(negedge clk);  // after second grant
    total++;
    if (grant_id !== ~exp_g) begin bad++; $display("FAIL prio_second: %b vs %b", grant_id, ~exp_g); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid_strobe();
    test_stretched();
    test_filter_prio();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
